braid_mix_sequencer: RTL
========================

Name: braid_mix_sequencer

Overview:
- Clocked controller that issues a generalised braid mixing schedule for CHANNELS fluid channels over STAGES stages, one mixer operation at a time.
- Successor to the static fixed-size braid netlists: channel count, stage count, partner offset and mix duration are all parametrised or run-time programmable.
- Sits between the schedule host (start/abort) and the valve/pump actuation layer (cmd valid/ready handshake).

Parameters:
- CHANNELS, 4, number of fluid channels (>=2)
- STAGES, 8, number of braid stages (>=1)
- TW, 8, width of mix-time field in cycles
- AW, derived max(1,$clog2(CHANNELS)), channel index width
- SW, derived max(1,$clog2(STAGES)), stage index width
- CW, derived $clog2(CHANNELS*STAGES+1), op counter width

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin schedule; sampled only in IDLE
- abort  in  1  cancel schedule; wins over all other events
- mix_time  in  TW  mix duration per op; sampled on accepted start
- cmd_valid  out  1  mixer command valid
- cmd_ready  in  1  actuation layer accepts command
- cmd_a  out  AW  first input channel of current op
- cmd_b  out  AW  partner channel of current op
- cmd_stage  out  SW  stage index of current op
- mixing  out  1  high during MIX countdown
- busy  out  1  high in ISSUE and MIX
- done  out  1  one-cycle pulse on schedule completion
- op_count  out  CW  completed ops since last accepted start

Behaviour:
- Interface: one clock clk; reset rst_n is asynchronous and active-low.
- Reset values: all outputs 0; state IDLE; internal stage/channel/timer 0.
- States: IDLE, ISSUE, MIX, DONE.
- IDLE: if start && !abort -> ISSUE; latch T = (mix_time==0) ? 1 : mix_time; clear op_count, stage s=0, channel c=0.
- ISSUE: cmd_valid=1, cmd_a=c, cmd_b=(c+1+(s mod (CHANNELS-1))) mod CHANNELS, cmd_stage=s.
  - cmd_a/cmd_b/cmd_stage stay stable while cmd_valid && !cmd_ready.
  - On cmd_valid && cmd_ready -> MIX; timer loaded with T.
- MIX: mixing=1, cmd_valid=0; timer decrements each cycle.
  - After exactly T MIX cycles, op_count increments.
  - Advance c; when c wraps from CHANNELS-1 to 0, advance s.
  - If the op just finished was (s=STAGES-1, c=CHANNELS-1) -> DONE, else -> ISSUE.
- DONE: done=1, busy=0 for one cycle -> IDLE. op_count holds until the next accepted start.
- Per-op latency with cmd_ready held high: 1 ISSUE cycle + T MIX cycles. Full schedule takes CHANNELS*STAGES*(1+T) busy cycles, then the done cycle.
- abort in ISSUE or MIX: next state IDLE, cmd_valid and mixing drop next cycle, no done pulse, op_count frozen. abort in IDLE or DONE has no effect on those states.
- start while busy is ignored; the schedule is not restarted.
- Async reset mid-operation: immediate return to reset values, no done pulse.
- CHANNELS==2: partner offset is always 1, so (0,1),(1,0) every stage.
- Arithmetic is all modular, with no out-of-range indices for non-power-of-2 CHANNELS/STAGES.

Optional Feature:
- Macro BRAID_MIX_SEQUENCER_STALL_EN.
- Defined: extra output port stall_cycles (32 bits, reset 0).
  - Cleared on accepted start.
  - Increments every cycle cmd_valid && !cmd_ready; saturates at all-ones.
  - Held through DONE/IDLE.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- CHANNELS=4, STAGES=2, mix_time=3, cmd_ready=1, start pulse:
  - pairs in order (0,1),(1,2),(2,3),(3,0) stage0, then (0,2),(1,3),(2,0),(3,1) stage1
  - busy high 32 cycles, then done for 1 cycle, op_count=8
- Same config, cmd_ready low 5 cycles on op 3:
  - cmd_a=2, cmd_b=3, cmd_stage=0 stable for 5 cycles
  - completion delayed by 5 cycles
  - with STALL_EN, stall_cycles=5
- mix_time=0: each MIX lasts 1 cycle; CHANNELS=4, STAGES=2 completes in 16 busy cycles.
- abort asserted during MIX of op 5:
  - next cycle state IDLE, cmd_valid=0, mixing=0
  - no done pulse, op_count=4
  - a new start runs a full schedule from (0,1).
- rst_n pulled low mid-ISSUE: outputs 0 asynchronously; after release, start produces a clean schedule.
- CHANNELS=3, STAGES=3, mix_time=2:
  - stage offsets 1,2,1; pairs include (2,0) at stage0 and (2,1) at stage1
  - op_count=9, done after 27 busy cycles.

Source files
------------

// File: rtl/braid_mix_sequencer.sv
// braid_mix_sequencer: issues a braid mixing schedule over CHANNELS channels
// and STAGES stages, one mixer operation at a time, through a valid/ready
// command handshake. Each op mixes channel c with its partner
// (c + 1 + (s mod (CHANNELS-1))) mod CHANNELS, then waits T mix cycles.
//
// Optional feature: define BRAID_MIX_SEQUENCER_STALL_EN to add the
// stall_cycles output, which counts handshake back-pressure cycles.
//
// state | meaning
// IDLE  | waiting for start
// ISSUE | presenting the current op on cmd_*, waiting for cmd_ready
// MIX   | mix timer counting down for the accepted op
// DONE  | one-cycle completion pulse
module braid_mix_sequencer #(
    parameter int CHANNELS = 4,
    parameter int STAGES   = 8,
    parameter int TW       = 8,
    localparam int AW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int SW = (STAGES > 1) ? $clog2(STAGES) : 1,
    localparam int CW = $clog2(CHANNELS * STAGES + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic [TW-1:0] mix_time,
    output logic          cmd_valid,
    input  logic          cmd_ready,
    output logic [AW-1:0] cmd_a,
    output logic [AW-1:0] cmd_b,
    output logic [SW-1:0] cmd_stage,
    output logic          mixing,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] op_count
`ifdef BRAID_MIX_SEQUENCER_STALL_EN
    ,
    output logic [31:0]   stall_cycles
`endif
);

    typedef enum logic [1:0] {IDLE, ISSUE, MIX, DONE} state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] chan;
    logic [SW-1:0] stage;
    logic [TW-1:0] timer;
    logic [TW-1:0] t_lat;
    logic          last_op;
    logic          accept_start;
    logic          mix_end;
    logic [AW-1:0] partner;

    assign accept_start = start && !abort;
    assign last_op      = (stage == SW'(STAGES - 1)) && (chan == AW'(CHANNELS - 1));
    assign mix_end      = (timer == TW'(1));

    // Partner index: all arithmetic kept modular so odd channel counts stay in range.
    assign partner = AW'((32'(chan) + 32'd1 + (32'(stage) % 32'(CHANNELS - 1)))
                         % 32'(CHANNELS));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic and state-decoded outputs; abort overrides every other event.
    always_comb begin
        state_nxt = state;
        cmd_valid = 1'b0;
        mixing    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        cmd_a     = '0;
        cmd_b     = '0;
        cmd_stage = '0;
        case (state)
            IDLE: begin
                if (accept_start) state_nxt = ISSUE;
            end
            ISSUE: begin
                cmd_valid = 1'b1;
                busy      = 1'b1;
                cmd_a     = chan;
                cmd_b     = partner;
                cmd_stage = stage;
                if (abort)          state_nxt = IDLE;
                else if (cmd_ready) state_nxt = MIX;
            end
            MIX: begin
                mixing = 1'b1;
                busy   = 1'b1;
                if (abort)        state_nxt = IDLE;
                else if (mix_end) state_nxt = last_op ? DONE : ISSUE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Schedule position, mix timer and completed-op counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chan     <= '0;
            stage    <= '0;
            timer    <= '0;
            t_lat    <= '0;
            op_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept_start) begin
                        t_lat    <= (mix_time == '0) ? TW'(1) : mix_time;
                        op_count <= '0;
                        chan     <= '0;
                        stage    <= '0;
                    end
                end
                ISSUE: begin
                    if (!abort && cmd_ready) timer <= t_lat;
                end
                MIX: begin
                    if (!abort) begin
                        timer <= timer - TW'(1);
                        if (mix_end) begin
                            op_count <= op_count + CW'(1);
                            if (chan == AW'(CHANNELS - 1)) begin
                                chan  <= '0;
                                stage <= (stage == SW'(STAGES - 1)) ? '0 : stage + SW'(1);
                            end else begin
                                chan <= chan + AW'(1);
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef BRAID_MIX_SEQUENCER_STALL_EN
    // Back-pressure counter: cleared on an accepted start, saturating, held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (state == IDLE && accept_start) begin
            stall_cycles <= '0;
        end else if (cmd_valid && !cmd_ready && stall_cycles != '1) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule
